// File: rtl/prbs_checker_if.sv
// prbs_checker_if
//   Valid/ready sample-word channel between the DAC-path pattern generator
//   and the PRBS checker.
//   i_data  : 32-bit sample word (generator -> checker)
//   i_valid : i_data is valid (generator -> checker)
//   i_ready : checker accepts a word (checker -> generator)
//   A beat is accepted when i_valid & i_ready.
interface prbs_checker_if;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_ready;

  modport master (output i_data, output i_valid, input i_ready);
  modport slave  (input i_data, input i_valid, output i_ready);
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker
//   Self-synchronising checker for the 32-bit Fibonacci LFSR sample stream
//   (taps 31, 29, 25, 24; shift left, feedback into bit 0). It seeds from the
//   incoming data, verifies LOCK_COUNT consecutive predictions, then free-runs
//   its predictor and gathers saturating word / errored-word / errored-bit
//   statistics while locked.
// Ports:
//   clk          : single clock
//   rst          : synchronous active-high reset
//   bus          : slave side of the sample channel (i_data, i_valid, i_ready)
//   clear        : synchronous statistics clear (lock state untouched)
//   locked       : checker is in LOCKED
//   word_cnt     : words accepted while locked
//   err_word_cnt : errored words while locked
//   err_bit_cnt  : sum of errored bits while locked
//   err_pulse    : one-cycle strobe per errored word
module prbs_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  prbs_checker_if.slave    bus,
  input  logic             clear,
  output logic             locked,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [CNT_W-1:0] err_bit_cnt,
  output logic             err_pulse
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);
  // Wide enough for counter + 6-bit popcount without losing the carry.
  localparam int SUM_W  = ((CNT_W > 6) ? CNT_W : 6) + 1;

  typedef enum logic [1:0] {SEEK, VERIFY, LOCKED} state_t;

  function automatic logic [31:0] nxt(input logic [31:0] w);
    return {w[30:0], w[31] ^ w[29] ^ w[25] ^ w[24]};
  endfunction

  state_t             state_reg;
  logic [31:0]        ref_word_reg;
  logic [GOOD_W-1:0]  good_cnt_reg;
  logic [BAD_W-1:0]   bad_run_reg;
  logic               ready_reg;
  logic               locked_reg;
  logic               err_pulse_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic [CNT_W-1:0]   err_word_cnt_reg;
  logic [CNT_W-1:0]   err_bit_cnt_reg;

  logic               accept;
  logic [31:0]        pred;
  logic [31:0]        err_vec;
  logic [5:0]         pop;
  logic [CNT_W-1:0]   word_cnt_next;
  logic [CNT_W-1:0]   err_word_cnt_next;
  logic [CNT_W-1:0]   err_bit_cnt_next;
  logic [SUM_W-1:0]   bit_sum;

  assign accept  = bus.i_valid & ready_reg;
  assign pred    = nxt(ref_word_reg);
  assign err_vec = bus.i_data ^ pred;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 32; i++) begin
      pop = pop + 6'(err_vec[i]);
    end
  end

  // Saturating next values for the statistics counters.
  always_comb begin
    word_cnt_next     = (word_cnt_reg == '1) ? word_cnt_reg : word_cnt_reg + CNT_W'(1);
    err_word_cnt_next = (err_word_cnt_reg == '1) ? err_word_cnt_reg
                                                 : err_word_cnt_reg + CNT_W'(1);
    bit_sum           = SUM_W'(err_bit_cnt_reg) + SUM_W'(pop);
    err_bit_cnt_next  = (bit_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                           : bit_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= SEEK;
      ref_word_reg     <= '0;
      good_cnt_reg     <= '0;
      bad_run_reg      <= '0;
      ready_reg        <= 1'b0;
      locked_reg       <= 1'b0;
      err_pulse_reg    <= 1'b0;
      word_cnt_reg     <= '0;
      err_word_cnt_reg <= '0;
      err_bit_cnt_reg  <= '0;
    end else begin
      // The generator cannot hold data, so ready stays high once out of reset.
      ready_reg     <= 1'b1;
      err_pulse_reg <= 1'b0;

      if (accept) begin
        case (state_reg)
          SEEK: begin
            // All-zero is the LFSR lock-up value and cannot seed a sequence.
            if (bus.i_data != 32'd0) begin
              ref_word_reg <= bus.i_data;
              good_cnt_reg <= '0;
              state_reg    <= VERIFY;
            end
          end

          VERIFY: begin
            if (bus.i_data == pred) begin
              ref_word_reg <= bus.i_data;
              good_cnt_reg <= good_cnt_reg + GOOD_W'(1);
              if (good_cnt_reg == GOOD_W'(LOCK_COUNT - 1)) begin
                state_reg   <= LOCKED;
                locked_reg  <= 1'b1;
                bad_run_reg <= '0;
              end
            end else begin
              good_cnt_reg <= '0;
              if (bus.i_data != 32'd0) begin
                ref_word_reg <= bus.i_data;
              end else begin
                state_reg <= SEEK;
              end
            end
          end

          LOCKED: begin
            // Free-running predictor: a corrupted word never reseeds it.
            ref_word_reg <= pred;
            word_cnt_reg <= word_cnt_next;
            if (err_vec != 32'd0) begin
              err_pulse_reg    <= 1'b1;
              err_word_cnt_reg <= err_word_cnt_next;
              err_bit_cnt_reg  <= err_bit_cnt_next;
              if (bad_run_reg == BAD_W'(UNLOCK_ERRS - 1)) begin
                state_reg   <= SEEK;
                locked_reg  <= 1'b0;
                bad_run_reg <= '0;
              end else begin
                bad_run_reg <= bad_run_reg + BAD_W'(1);
              end
            end else begin
              bad_run_reg <= '0;
            end
          end

          default: begin
            state_reg  <= SEEK;
            locked_reg <= 1'b0;
          end
        endcase
      end

      // Placed last so it overrides any same-cycle beat contribution.
      if (clear) begin
        word_cnt_reg     <= '0;
        err_word_cnt_reg <= '0;
        err_bit_cnt_reg  <= '0;
      end
    end
  end

  assign bus.i_ready   = ready_reg;
  assign locked        = locked_reg;
  assign word_cnt      = word_cnt_reg;
  assign err_word_cnt  = err_word_cnt_reg;
  assign err_bit_cnt   = err_bit_cnt_reg;
  assign err_pulse     = err_pulse_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
//   Drives two checker instances (default parameters, and CNT_W=4 with
//   UNLOCK_ERRS=32) with the same directed stream. A behavioural model
//   predicts every output each cycle; hand-computed literal expectations
//   pin the key events (lock/unlock timing, counter values, saturation, clear).
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] tb_data = 32'd0;
  logic        tb_valid = 1'b0;

  always #5 clk = ~clk;

  prbs_checker_if bus0();
  prbs_checker_if bus1();

  assign bus0.i_data  = tb_data;
  assign bus0.i_valid = tb_valid;
  assign bus1.i_data  = tb_data;
  assign bus1.i_valid = tb_valid;

  logic        lk0, p0, lk1, p1;
  logic [31:0] wc0, ewc0, ebc0;
  logic [3:0]  wc1, ewc1, ebc1;

  prbs_checker dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .clear(clear), .locked(lk0),
    .word_cnt(wc0), .err_word_cnt(ewc0), .err_bit_cnt(ebc0), .err_pulse(p0)
  );

  prbs_checker #(.LOCK_COUNT(16), .UNLOCK_ERRS(32), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .clear(clear), .locked(lk1),
    .word_cnt(wc1), .err_word_cnt(ewc1), .err_bit_cnt(ebc1), .err_pulse(p1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Next LFSR word: shift left, new bit 0 is the parity of the tapped bits.
  function automatic logic [31:0] m_nxt(input logic [31:0] w);
    logic [31:0] taps;
    taps = w & 32'hA300_0000;
    return (w << 1) | {31'd0, ^taps};
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input longint mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  int          p_lc [2] = '{16, 16};
  int          p_ue [2] = '{8, 32};
  longint      p_max[2] = '{64'hFFFF_FFFF, 64'd15};

  int          m_mode[2];  // 0 = seeking, 1 = verifying, 2 = locked
  logic [31:0] m_ref [2];
  int          m_good[2];
  int          m_bad [2];
  longint      m_wc  [2];
  longint      m_ewc [2];
  longint      m_ebc [2];
  logic        m_ready [2];
  logic        m_locked[2];
  logic        m_pulse [2];
  bit          started = 1'b0;

  task automatic model_step(input int k);
    logic [31:0] p, x;
    if (rst) begin
      m_mode[k] = 0; m_ref[k] = 32'd0; m_good[k] = 0; m_bad[k] = 0;
      m_wc[k] = 0; m_ewc[k] = 0; m_ebc[k] = 0;
      m_ready[k] = 1'b0; m_locked[k] = 1'b0; m_pulse[k] = 1'b0;
    end else begin
      m_pulse[k] = 1'b0;
      if (tb_valid && m_ready[k]) begin
        if (m_mode[k] == 0) begin
          if (tb_data != 32'd0) begin
            m_ref[k] = tb_data; m_good[k] = 0; m_mode[k] = 1;
          end
        end else if (m_mode[k] == 1) begin
          if (tb_data == m_nxt(m_ref[k])) begin
            m_ref[k] = tb_data;
            m_good[k]++;
            if (m_good[k] == p_lc[k]) begin m_mode[k] = 2; m_bad[k] = 0; end
          end else begin
            m_good[k] = 0;
            if (tb_data != 32'd0) m_ref[k] = tb_data;
            else m_mode[k] = 0;
          end
        end else begin
          p = m_nxt(m_ref[k]);
          m_ref[k] = p;
          x = tb_data ^ p;
          m_wc[k] = sat_add(m_wc[k], 1, p_max[k]);
          if (x != 32'd0) begin
            m_ewc[k] = sat_add(m_ewc[k], 1, p_max[k]);
            m_ebc[k] = sat_add(m_ebc[k], longint'($countones(x)), p_max[k]);
            m_pulse[k] = 1'b1;
            m_bad[k]++;
            if (m_bad[k] == p_ue[k]) m_mode[k] = 0;
          end else begin
            m_bad[k] = 0;
          end
        end
      end
      if (clear) begin m_wc[k] = 0; m_ewc[k] = 0; m_ebc[k] = 0; end
      m_ready[k]  = 1'b1;
      m_locked[k] = (m_mode[k] == 2);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
    started = 1'b1;
  end

  task automatic cmp_dut(input int k, input logic rdy, input logic lk, input logic [31:0] wc,
                         input logic [31:0] ewc, input logic [31:0] ebc, input logic p);
    chk($sformatf("dut%0d i_ready", k),      64'(rdy), 64'(m_ready[k]));
    chk($sformatf("dut%0d locked", k),       64'(lk),  64'(m_locked[k]));
    chk($sformatf("dut%0d word_cnt", k),     64'(wc),  64'(m_wc[k]));
    chk($sformatf("dut%0d err_word_cnt", k), 64'(ewc), 64'(m_ewc[k]));
    chk($sformatf("dut%0d err_bit_cnt", k),  64'(ebc), 64'(m_ebc[k]));
    chk($sformatf("dut%0d err_pulse", k),    64'(p),   64'(m_pulse[k]));
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      cmp_dut(0, bus0.i_ready, lk0, wc0, ewc0, ebc0, p0);
      cmp_dut(1, bus1.i_ready, lk1, {28'd0, wc1}, {28'd0, ewc1}, {28'd0, ebc1}, p1);
    end
  end

  // ---------------- directed stimulus ----------------
  // Inputs are applied 2 time units after a rising edge and consumed by the next one.
  task automatic drive(input logic [31:0] d, input logic v, input logic c);
    tb_data  = d;
    tb_valid = v;
    clear    = c;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] gen;
  logic        v;
  int          nv;

  initial begin
    // Reset held 5 cycles with valid high.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(32'hDEAD_BEEF, 1'b1, 1'b0);
      chk("reset i_ready", 64'(bus0.i_ready), 64'd0);
      chk("reset locked",  64'(lk0), 64'd0);
      chk("reset word_cnt", 64'(wc0), 64'd0);
      chk("reset err_pulse", 64'(p0), 64'd0);
    end
    rst = 1'b0;
    drive(32'd0, 1'b0, 1'b0);
    chk("ready after reset", 64'(bus0.i_ready), 64'd1);
    $display("reset released, i_ready=%0b", bus0.i_ready);

    // Clean lock from seed 0xFFFFFFFF.
    gen = 32'hFFFF_FFFF;
    for (int b = 1; b <= 17; b++) begin
      drive(gen, 1'b1, 1'b0);
      $display("lock beat %0d data=%08h locked=%0b", b, gen, lk0);
      gen = m_nxt(gen);
      chk("lock timing dut0", 64'(lk0), 64'(b == 17));
      chk("lock timing dut1", 64'(lk1), 64'(b == 17));
    end
    for (int i = 0; i < 100; i++) begin
      drive(gen, 1'b1, 1'b0);
      gen = m_nxt(gen);
    end
    $display("after 100 clean beats word_cnt=%0d errs=%0d/%0d", wc0, ewc0, ebc0);
    chk("clean word_cnt", 64'(wc0), 64'd100);
    chk("clean err_word_cnt", 64'(ewc0), 64'd0);
    chk("clean err_bit_cnt", 64'(ebc0), 64'd0);
    chk("clean word_cnt sat4", 64'(wc1), 64'd15);

    // Single-bit error on bit 7.
    drive(gen ^ 32'h0000_0080, 1'b1, 1'b0);
    gen = m_nxt(gen);
    $display("bit7 error beat: pulse=%0b ewc=%0d ebc=%0d", p0, ewc0, ebc0);
    chk("1bit err_pulse", 64'(p0), 64'd1);
    chk("1bit err_word_cnt", 64'(ewc0), 64'd1);
    chk("1bit err_bit_cnt", 64'(ebc0), 64'd1);
    chk("1bit locked", 64'(lk0), 64'd1);
    drive(gen, 1'b1, 1'b0);
    gen = m_nxt(gen);
    $display("beat after error: pulse=%0b ewc=%0d", p0, ewc0);
    chk("1bit next pulse", 64'(p0), 64'd0);
    chk("1bit next err_word_cnt", 64'(ewc0), 64'd1);
    chk("1bit next locked", 64'(lk0), 64'd1);

    // Clear on a clean beat, then an 8-beat 0x0F burst.
    drive(gen, 1'b1, 1'b1);
    gen = m_nxt(gen);
    chk("clear word_cnt", 64'(wc0), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      drive(gen ^ 32'h0000_000F, 1'b1, 1'b0);
      $display("burst beat %0d locked=%0b ewc=%0d", i, lk0, ewc0);
      gen = m_nxt(gen);
      chk("burst unlock timing", 64'(lk0), 64'(i < 8));
    end
    chk("burst err_word_cnt", 64'(ewc0), 64'd8);
    chk("burst err_bit_cnt", 64'(ebc0), 64'd32);
    chk("burst word_cnt", 64'(wc0), 64'd8);
    chk("burst dut1 locked", 64'(lk1), 64'd1);
    chk("burst dut1 err_bit clamp", 64'(ebc1), 64'd15);
    for (int b = 1; b <= 17; b++) begin
      drive(gen, 1'b1, 1'b0);
      gen = m_nxt(gen);
      chk("relock timing", 64'(lk0), 64'(b == 17));
    end
    $display("relocked=%0b ewc=%0d ebc=%0d wc=%0d", lk0, ewc0, ebc0, wc0);
    chk("relock err_word_cnt", 64'(ewc0), 64'd8);
    chk("relock err_bit_cnt", 64'(ebc0), 64'd32);
    chk("relock word_cnt", 64'(wc0), 64'd8);

    // Random valid gaps; idle cycles carry junk data that must be ignored.
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      drive(v ? gen : $urandom, v, 1'b0);
      if (v) begin gen = m_nxt(gen); nv++; end
    end
    $display("gaps: %0d valid beats, word_cnt=%0d ewc=%0d", nv, wc0, ewc0);
    chk("gaps word_cnt", 64'(wc0), 64'(8 + nv));
    chk("gaps err_word_cnt", 64'(ewc0), 64'd8);
    chk("gaps locked", 64'(lk0), 64'd1);

    // Reset mid-lock, then a constant lock-up value.
    rst = 1'b1;
    drive(gen, 1'b1, 1'b0);
    chk("midlock reset locked", 64'(lk0), 64'd0);
    chk("midlock reset word_cnt", 64'(wc0), 64'd0);
    drive(gen, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(32'd0, 1'b1, 1'b0);
      chk("zeros locked", 64'(lk0), 64'd0);
    end
    $display("after 40 zero words locked=%0b", lk0);

    // Lock both, then 20 single-bit errored words to saturate the 4-bit counters.
    for (int b = 1; b <= 17; b++) begin
      drive(gen, 1'b1, 1'b0);
      gen = m_nxt(gen);
    end
    chk("sat lock dut0", 64'(lk0), 64'd1);
    chk("sat lock dut1", 64'(lk1), 64'd1);
    for (int i = 0; i < 20; i++) begin
      drive(gen ^ 32'h1, 1'b1, 1'b0);
      gen = m_nxt(gen);
    end
    $display("sat: dut1 wc=%0d ewc=%0d ebc=%0d locked=%0b", wc1, ewc1, ebc1, lk1);
    chk("sat err_word_cnt", 64'(ewc1), 64'd15);
    chk("sat err_bit_cnt", 64'(ebc1), 64'd15);
    chk("sat word_cnt", 64'(wc1), 64'd15);
    chk("sat dut1 locked", 64'(lk1), 64'd1);
    chk("sat dut0 unlocked", 64'(lk0), 64'd0);

    // Clear coinciding with an errored beat.
    drive(gen ^ 32'h1, 1'b1, 1'b1);
    gen = m_nxt(gen);
    $display("clear+error: wc=%0d ewc=%0d ebc=%0d pulse=%0b locked=%0b", wc1, ewc1, ebc1, p1, lk1);
    chk("clr word_cnt", 64'(wc1), 64'd0);
    chk("clr err_word_cnt", 64'(ewc1), 64'd0);
    chk("clr err_bit_cnt", 64'(ebc1), 64'd0);
    chk("clr err_pulse", 64'(p1), 64'd1);
    chk("clr locked", 64'(lk1), 64'd1);

    drive(32'd0, 1'b0, 1'b0);
    drive(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Downstream consumer for the DAC-path test-pattern generator. Accepts 32-bit words over a valid/ready handshake and self-synchronises to the generator's 32-bit Fibonacci LFSR sequence (taps 31, 29, 25, 24; shift-left, feedback into bit 0). Once locked, it counts accepted words, errored words and errored bits. It is used for loopback and bring-up checks of the sample path between the generator and the DAC interface.

## Interface
- `LOCK_COUNT`, default 16: consecutive correctly predicted words needed to declare lock.
- `UNLOCK_ERRS`, default 8: consecutive errored words in LOCKED that drop lock.
- `CNT_W`, default 32: width of the statistics counters; all counters saturate.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `i_data`  in  32  input sample word.
- `i_valid`  in  1  `i_data` is valid.
- `i_ready`  out  1  checker accepts a word; a beat is accepted when `i_valid & i_ready`.
- `clear`  in  1  synchronous counter clear; lock state is not affected.
- `locked`  out  1  high in state LOCKED.
- `word_cnt`  out  CNT_W  words accepted while LOCKED.
- `err_word_cnt`  out  CNT_W  errored words while LOCKED.
- `err_bit_cnt`  out  CNT_W  sum of errored bits while LOCKED.
- `err_pulse`  out  1  one-cycle strobe for each errored word.

## Operation
- The next-word function is `nxt(w) = {w[30:0], w[31]^w[29]^w[25]^w[24]}`. Prediction advances once per accepted beat only; idle (`i_valid` low) cycles do not advance it.
- `i_ready` is registered. It is 0 in reset and 1 from the first cycle after `rst` deasserts. It never deasserts otherwise, because the generator does not hold data under back-pressure.
- Internal state: `ref` (32 b), `good_cnt`, `bad_run`, FSM with states SEEK, VERIFY and LOCKED.
- **SEEK:**
  - On an accepted non-zero word: set `ref` to the word, clear `good_cnt`, go to VERIFY.
  - An all-zero word is the LFSR lock-up value. It is ignored and the FSM stays in SEEK.
- **VERIFY:**
  - On an accepted word equal to `nxt(ref)`: set `ref` to the word and increment `good_cnt`. When `good_cnt` reaches LOCK_COUNT, go to LOCKED and clear `bad_run`.
  - On a mismatch: reseed `ref` from the word (if it is non-zero, else go to SEEK) and clear `good_cnt`.
  - No statistics counters change in VERIFY.
- **LOCKED:**
  - On each accepted word, set `ref` to `nxt(ref)`. The predictor free-runs and never reseeds from data, so an isolated error does not propagate into following predictions.
  - `word_cnt` increments.
  - If `x = i_data ^ nxt(ref)` is non-zero:
    - `err_word_cnt` increments.
    - `err_bit_cnt` increases by popcount(x), in the range 1..32.
    - `err_pulse` is high for one cycle.
    - `bad_run` increments.
  - If `x` is zero, `bad_run` is cleared.
  - When `bad_run` reaches UNLOCK_ERRS, go to SEEK.
- **Arithmetic:**
  - All counters saturate at all-ones and never wrap.
  - `err_bit_cnt` clamps when the sum would exceed all-ones.
  - The popcount is 6 bits wide.
- **`clear` handling:**
  - `clear` zeroes `word_cnt`, `err_word_cnt` and `err_bit_cnt`.
  - If `clear` coincides with an accepted beat, `clear` wins and that beat's contributions are dropped.
  - `err_pulse` still fires for that beat.
- **`rst` handling:** `rst` at any time, including mid-lock, forces SEEK, zeroes all counters and internal state, and drives all outputs low.

## Timing
- **Reset values:** `i_ready`=0, `locked`=0, `word_cnt`=0, `err_word_cnt`=0, `err_bit_cnt`=0, `err_pulse`=0.
- All outputs are registered. The effects of an accepted beat on cycle N (state, counters, `err_pulse`, `locked`) are visible on cycle N+1.
- **Lock latency:** the seed beat plus LOCK_COUNT matching beats are required. With the default LOCK_COUNT and back-to-back beats, `locked` rises one cycle after the 17th accepted beat.
- **Unlock latency:** `locked` falls one cycle after the UNLOCK_ERRS-th consecutive errored beat. The counters include that beat.
- Any accepted beat after unlock is treated as a fresh SEEK seed.
- There is one compare per clock at full rate. Throughput is one word per cycle.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` for 5 cycles while `i_valid`=1.
  - Required: all outputs 0 during reset; `i_ready` = 1 on the first cycle after release.
- **Clean lock:**
  - Stimulus: stream seeded at 0xFFFFFFFF (0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFC, …), back-to-back.
  - Required: `locked` rises one cycle after beat 17. After 100 further beats, `word_cnt`=100 and both error counters are 0.
- **Single-bit error in LOCKED:**
  - Stimulus: flip bit 7 of one beat.
  - Required: `err_word_cnt`=1, `err_bit_cnt`=1, `err_pulse` high for exactly one cycle, the next beat has no error, and `locked` stays 1.
- **Burst error and relock:**
  - Stimulus: XOR 0x0000000F into 8 consecutive beats.
  - Required: `err_word_cnt`=8 and `err_bit_cnt`=32. `locked` falls after the 8th beat and rises again 17 clean beats later; the counters are retained.
- **Gaps and lock-up value:**
  - Stimulus: random `i_valid` gaps within a correct stream.
  - Required: zero errors.
  - Stimulus: constant 0x00000000.
  - Required: the checker stays in SEEK and `locked` never rises.
- **Saturation and clear:**
  - Stimulus: CNT_W=4 with 20 errored words (UNLOCK_ERRS=32).
  - Required: `err_word_cnt`=15 and `err_bit_cnt`=15.
  - Stimulus: `clear` asserted together with an errored beat.
  - Required: counters read 0 the next cycle, `err_pulse`=1, and `locked` is unchanged.
